// File: rtl/fft_output_reorder.sv
// fft_output_reorder: ping-pong frame buffer turning bit-reversed FFT bins into natural order
module fft_output_reorder #(
    parameter int DW = 19,
    parameter int LOG2N = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [DW-1:0]    data_in_r,
    input  logic [DW-1:0]    data_in_i,
    output logic             valid_o,
    output logic [DW-1:0]    data_out_r,
    output logic [DW-1:0]    data_out_i,
    output logic [LOG2N-1:0] index_o,
    output logic             last_o
);
    localparam int N = 1 << LOG2N;
    typedef enum logic {IDLE, READ} state_t;
    state_t state, state_nx;
    logic [2*DW-1:0] mem [2*N];
    logic [LOG2N-1:0] wr_cnt, wr_rev, rd_cnt, rd_cnt_nx;
    logic wr_bank, rd_bank, rd_bank_nx, rd_last, wr_last;
    logic [1:0] full, full_nx;
    for (genvar b = 0; b < LOG2N; b++) begin : g_rev
        assign wr_rev[b] = wr_cnt[LOG2N-1-b];
    end
    assign wr_last = valid_i && wr_cnt == LOG2N'(N-1);
    assign rd_last = state == READ && rd_cnt == LOG2N'(N-1);
    always_comb begin
        full_nx = full;
        if (wr_last) full_nx[wr_bank] = 1'b1;
        if (rd_last) full_nx[rd_bank] = 1'b0;
        rd_bank_nx = rd_last ? ~rd_bank : rd_bank;
        rd_cnt_nx = state == READ ? rd_cnt + 1'b1 : '0;
        state_nx = state;
        if (state == IDLE) state_nx = full[rd_bank] ? READ : IDLE;
        else if (rd_last) state_nx = full[~rd_bank] ? READ : IDLE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            rd_cnt <= '0;
            rd_bank <= 1'b0;
            full <= '0;
            wr_cnt <= '0;
            wr_bank <= 1'b0;
            valid_o <= 1'b0;
            last_o <= 1'b0;
            index_o <= '0;
            data_out_r <= '0;
            data_out_i <= '0;
        end else begin
            state <= state_nx;
            rd_cnt <= rd_cnt_nx;
            rd_bank <= rd_bank_nx;
            full <= full_nx;
            if (valid_i) wr_cnt <= wr_cnt + 1'b1;
            if (wr_last) wr_bank <= ~wr_bank;
            valid_o <= state == READ;
            last_o <= rd_last;
            index_o <= state == READ ? rd_cnt : '0;
            {data_out_r, data_out_i} <= state == READ ? mem[{rd_bank, rd_cnt}] : '0;
        end
    end
    // Storage needs no reset; a bank is only read after a complete frame has been written.
    always_ff @(posedge clk) begin
        if (valid_i) mem[{wr_bank, wr_rev}] <= {data_in_r, data_in_i};
    end
endmodule

// File: tb/tb_fft_output_reorder.sv
// tb_fft_output_reorder: randomized frames checked against a natural-order reference model
module tb_fft_output_reorder;
    localparam int DW = 19;
    typedef logic [DW-1:0] frame_t [32];
    typedef struct {
        int cyc;
        logic [4:0] idx;
        logic last;
        logic [DW-1:0] r;
        logic [DW-1:0] i;
    } rec_t;

    logic clk = 0, rst = 0, valid_i = 0;
    logic [DW-1:0] data_in_r = '0, data_in_i = '0, data_out_r, data_out_i;
    logic valid_o, last_o;
    logic [4:0] index_o;
    int cyc = 0, last_edge = 0, stray_last = 0, tests = 0, fails = 0;
    rec_t got[$];
    logic [DW-1:0] exp_r[$], exp_i[$];

    fft_output_reorder #(.DW(DW), .LOG2N(5)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .data_in_r(data_in_r), .data_in_i(data_in_i),
        .valid_o(valid_o), .data_out_r(data_out_r), .data_out_i(data_out_i),
        .index_o(index_o), .last_o(last_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (valid_o) got.push_back('{cyc, index_o, last_o, data_out_r, data_out_i});
        if (last_o && !valid_o) stray_last++;
    end

    function automatic int brev(input int k);
        int v = 0;
        for (int b = 0; b < 5; b++) if (k & (1 << b)) v |= 1 << (4 - b);
        return v;
    endfunction

    task automatic put(input logic [DW-1:0] r, input logic [DW-1:0] i);
        valid_i = 1; data_in_r = r; data_in_i = i;
        @(posedge clk); #1;
        valid_i = 0;
        last_edge = cyc;
    endtask

    // Output bin n of a frame is the sample that arrived at position brev(n).
    task automatic send_frame(input frame_t r, input frame_t i, input int gap_mode);
        for (int k = 0; k < 32; k++) begin
            put(r[k], i[k]);
            if (k < 31) repeat (gap_mode == 1 ? 1 : gap_mode == 2 ? $urandom_range(3) : 0) begin
                @(posedge clk); #1;
            end
        end
        for (int n = 0; n < 32; n++) begin
            exp_r.push_back(r[brev(n)]);
            exp_i.push_back(i[brev(n)]);
        end
    endtask

    task automatic drain();
        int b = 0;
        while (got.size() < exp_r.size() && b < 300) begin
            @(posedge clk); b++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic clear();
        got.delete(); exp_r.delete(); exp_i.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++;
        if ({valid_o, last_o, index_o, data_out_r, data_out_i} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got v=%0b l=%0b idx=%0d r=%0h i=%0h want all 0",
                     valid_o, last_o, index_o, data_out_r, data_out_i);
        end
        @(posedge clk); #1;
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (valid_o !== 1'b0 || got.size() != 0) begin
            fails++; $display("FAIL reset_idle got valid_o=%0b outputs=%0d want 0/0", valid_o, got.size());
        end
    endtask

    task automatic test_natural_order();
        frame_t r, i;
        clear();
        for (int k = 0; k < 32; k++) begin r[k] = DW'(k); i[k] = DW'(-k); end
        send_frame(r, i, 0);
        drain();
        tests++;
        if (got.size() != 32) begin fails++; $display("FAIL nat_count got %0d want 32", got.size()); end
        tests++;
        if (got.size() > 0 && got[0].cyc != last_edge + 2) begin
            fails++; $display("FAIL latency got first output edge %0d want %0d", got[0].cyc, last_edge + 2);
        end
        foreach (got[n]) if (n < exp_r.size()) begin
            tests++;
            if (got[n].r !== exp_r[n] || got[n].i !== exp_i[n] || got[n].idx !== 5'(n) ||
                got[n].last !== (n % 32 == 31) || got[n].cyc != got[0].cyc + n) begin
                fails++;
                $display("FAIL nat_bin%0d got r=%0h i=%0h idx=%0d last=%0b cyc=%0d want r=%0h i=%0h idx=%0d last=%0b cyc=%0d",
                         n, got[n].r, got[n].i, got[n].idx, got[n].last, got[n].cyc,
                         exp_r[n], exp_i[n], n % 32, n % 32 == 31, got[0].cyc + n);
            end
        end
    endtask

    task automatic test_back_to_back();
        frame_t r, i;
        clear();
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 32; k++) begin r[k] = DW'($urandom); i[k] = DW'($urandom); end
            send_frame(r, i, 0);
        end
        drain();
        tests++;
        if (got.size() != 96) begin fails++; $display("FAIL b2b_count got %0d want 96", got.size()); end
        foreach (got[n]) if (n < exp_r.size()) begin
            tests++;
            if (got[n].r !== exp_r[n] || got[n].i !== exp_i[n] || got[n].idx !== 5'(n) ||
                got[n].last !== (n % 32 == 31) || got[n].cyc != got[0].cyc + n) begin
                fails++;
                $display("FAIL b2b_out%0d got r=%0h i=%0h idx=%0d last=%0b cyc=%0d want r=%0h i=%0h idx=%0d last=%0b cyc=%0d",
                         n, got[n].r, got[n].i, got[n].idx, got[n].last, got[n].cyc,
                         exp_r[n], exp_i[n], n % 32, n % 32 == 31, got[0].cyc + n);
            end
        end
    endtask

    task automatic test_gapped(input int gap_mode);
        frame_t r, i;
        int first_valid;
        clear();
        for (int k = 0; k < 32; k++) begin
            r[k] = gap_mode == 1 ? DW'(k) : DW'($urandom);
            i[k] = gap_mode == 1 ? DW'(-k) : DW'($urandom);
        end
        send_frame(r, i, gap_mode);
        drain();
        tests++;
        if (got.size() != 32) begin fails++; $display("FAIL gap%0d_count got %0d want 32", gap_mode, got.size()); end
        first_valid = got.size() > 0 ? got[0].cyc : -1;
        tests++;
        if (first_valid != last_edge + 2) begin
            fails++; $display("FAIL gap%0d_start got edge %0d want %0d", gap_mode, first_valid, last_edge + 2);
        end
        foreach (got[n]) if (n < exp_r.size()) begin
            tests++;
            if (got[n].r !== exp_r[n] || got[n].i !== exp_i[n] || got[n].idx !== 5'(n) ||
                got[n].last !== (n == 31) || got[n].cyc != got[0].cyc + n) begin
                fails++;
                $display("FAIL gap%0d_bin%0d got r=%0h i=%0h idx=%0d last=%0b want r=%0h i=%0h idx=%0d last=%0b",
                         gap_mode, n, got[n].r, got[n].i, got[n].idx, got[n].last,
                         exp_r[n], exp_i[n], n, n == 31);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        frame_t r, i;
        clear();
        for (int k = 0; k < 32; k++) begin r[k] = DW'($urandom); i[k] = DW'($urandom); end
        send_frame(r, i, 0);
        for (int k = 0; k < 20; k++) put(DW'(500 + k), DW'(k));
        rst = 0;
        #1;
        tests++;
        if (valid_o !== 1'b0 || data_out_r !== '0) begin
            fails++; $display("FAIL async_reset got valid_o=%0b r=%0h want 0/0", valid_o, data_out_r);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        clear();
        for (int k = 0; k < 32; k++) begin r[k] = DW'(100 + k); i[k] = DW'(-k); end
        send_frame(r, i, 0);
        drain();
        tests++;
        if (got.size() != 32) begin fails++; $display("FAIL rst_mid_count got %0d want 32", got.size()); end
        foreach (got[n]) if (n < 32) begin
            tests++;
            if (got[n].r !== DW'(100 + brev(n)) || got[n].i !== exp_i[n] || got[n].idx !== 5'(n) ||
                got[n].last !== (n == 31)) begin
                fails++;
                $display("FAIL rst_mid_bin%0d got r=%0d i=%0h idx=%0d last=%0b want r=%0d i=%0h idx=%0d last=%0b",
                         n, got[n].r, got[n].i, got[n].idx, got[n].last, 100 + brev(n), exp_i[n], n, n == 31);
            end
        end
    endtask

    task automatic test_extremes();
        frame_t r, i;
        clear();
        for (int k = 0; k < 32; k++) begin
            r[k] = k % 2 ? DW'(262143) : DW'(-262144);
            i[k] = k % 2 ? DW'(-262144) : DW'(262143);
        end
        send_frame(r, i, 0);
        drain();
        tests++;
        if (got.size() != 32) begin fails++; $display("FAIL ext_count got %0d want 32", got.size()); end
        foreach (got[n]) if (n < 32) begin
            tests++;
            if (got[n].r !== exp_r[n] || got[n].i !== exp_i[n] || got[n].idx !== 5'(n)) begin
                fails++;
                $display("FAIL ext_bin%0d got r=%0h i=%0h idx=%0d want r=%0h i=%0h idx=%0d",
                         n, got[n].r, got[n].i, got[n].idx, exp_r[n], exp_i[n], n);
            end
        end
        tests++;
        if (stray_last != 0) begin fails++; $display("FAIL stray_last got %0d want 0", stray_last); end
    endtask

    initial begin
        test_reset();
        test_natural_order();
        test_back_to_back();
        test_gapped(1);
        test_gapped(2);
        test_reset_mid_frame();
        test_extremes();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout got no completion want finish before 400000");
        $fatal(1, "timeout");
    end
endmodule
